// File: rtl/gate_array_pkg.sv
// Shared op encoding, packet state and base-op helpers for gate_array_pipe.
package gate_array_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pkt_state_e;

    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } base_e;

    // Base fold operation underlying an op; PASS/NOT do not use the fold.
    function automatic base_e base_of(input logic [2:0] op);
        case (op)
            OP_AND, OP_NAND: return BASE_AND;
            OP_OR,  OP_NOR:  return BASE_OR;
            default:         return BASE_XOR;
        endcase
    endfunction

    // Ops whose final value is inverted once.
    function automatic logic inv_of(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR) || (op == OP_NOT);
    endfunction

    // Ops that forward operand 0 instead of the folded value.
    function automatic logic pass_of(input logic [2:0] op);
        return (op == OP_PASS) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/gate_reduce.sv
// Combinational NIN-operand bitwise reducer for one base op.
module gate_reduce
    import gate_array_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NIN   = 4
) (
    input  logic [NIN*WIDTH-1:0] data,
    input  base_e                base,
    output logic [WIDTH-1:0]     result_c
);

    // Fold operands 1..NIN-1 onto operand 0.
    always_comb begin
        result_c = data[WIDTH-1:0];
        for (int unsigned k = 1; k < NIN; k++) begin
            case (base)
                BASE_AND: result_c = result_c & data[k*WIDTH +: WIDTH];
                BASE_OR:  result_c = result_c | data[k*WIDTH +: WIDTH];
                default:  result_c = result_c ^ data[k*WIDTH +: WIDTH];
            endcase
        end
    end

endmodule

// File: rtl/gate_array_pipe.sv
// Bitwise gate array over NIN operands with per-beat and packet-accumulation modes.
module gate_array_pipe
    import gate_array_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NIN   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NIN*WIDTH-1:0] in_data,
    input  logic [2:0]           op,
    input  logic                 acc_en,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    pkt_state_e       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic [2:0]       eff_op_c;
    base_e            base_c;
    logic [WIDTH-1:0] red_c;
    logic [WIDTH-1:0] fold_c;
    logic [WIDTH-1:0] res_c;
    logic             xfer_c;
    logic             emit_c;

    // Mid-packet beats use the op latched on the first beat.
    assign eff_op_c = (state_q == ACCUM) ? op_q : op;
    assign base_c   = base_of(eff_op_c);
    assign in_ready = !out_valid_q || out_ready;
    assign xfer_c   = in_valid && in_ready;

    gate_reduce #(
        .WIDTH (WIDTH),
        .NIN   (NIN)
    ) u_reduce (
        .data     (in_data),
        .base     (base_c),
        .result_c (red_c)
    );

    // Merge this beat into the running fold and form the final result.
    always_comb begin
        fold_c = red_c;
        if (state_q == ACCUM) begin
            case (base_c)
                BASE_AND: fold_c = acc_q & red_c;
                BASE_OR:  fold_c = acc_q | red_c;
                default:  fold_c = acc_q ^ red_c;
            endcase
        end
        res_c = pass_of(eff_op_c) ? in_data[WIDTH-1:0] : fold_c;
        if (inv_of(eff_op_c)) begin
            res_c = ~res_c;
        end
    end

    // Next-state, accumulator and output register updates.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        emit_c      = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (xfer_c) begin
                    if (acc_en && !in_last) begin
                        state_d = ACCUM;
                        op_d    = op;
                        acc_d   = fold_c;
                    end else begin
                        emit_c = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (xfer_c) begin
                    if (in_last) begin
                        state_d = IDLE;
                        emit_c  = 1'b1;
                    end else begin
                        acc_d = fold_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit_c) begin
            out_valid_d = 1'b1;
            out_data_d  = res_c;
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 3'b000;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gate_array_pipe.sv
// Self-checking bench for gate_array_pipe against a packet-level reference model.
module tb_gate_array_pipe;
    import gate_array_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [2:0]     op;
    logic           acc_en;
    logic           in_last;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;

    int total = 0;
    int bad   = 0;
    bit rnd_ready = 1'b0;

    // Reference model state: expected outputs and the operands of the open packet.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_ops[$];
    bit           m_in_pkt = 1'b0;
    logic [2:0]   m_op = 3'b000;

    gate_array_pipe #(.WIDTH(W), .NIN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .op        (op),
        .acc_en    (acc_en),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand k of the beat sits at bits [k*W +: W].
    function automatic logic [N*W-1:0] pk(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                          input logic [W-1:0] a2, input logic [W-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Result of a whole packet given all its operands and the last beat's operand 0.
    function automatic logic [W-1:0] model_eval(input logic [2:0] o, input logic [W-1:0] op0);
        logic [W-1:0] a = '1;
        logic [W-1:0] r = '0;
        logic [W-1:0] x = '0;
        foreach (m_ops[i]) begin
            a = a & m_ops[i];
            r = r | m_ops[i];
            x = x ^ m_ops[i];
        end
        case (o)
            3'd0:    return a;
            3'd1:    return r;
            3'd2:    return x;
            3'd3:    return ~a;
            3'd4:    return ~r;
            3'd5:    return ~x;
            3'd6:    return op0;
            default: return ~op0;
        endcase
    endfunction

    task automatic model_beat(input logic [N*W-1:0] d, input logic [2:0] o,
                              input logic ae, input logic last);
        if (!m_in_pkt) begin
            m_op = o;
            m_ops.delete();
        end
        for (int k = 0; k < int'(N); k++) m_ops.push_back(d[k*W +: W]);
        if (!m_in_pkt && ae && !last) begin
            m_in_pkt = 1'b1;
        end else if (!m_in_pkt || last) begin
            exp_q.push_back(model_eval(m_op, d[W-1:0]));
            m_in_pkt = 1'b0;
        end
    endtask

    // Compare process: checks handshake, output timing and data every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_in_pkt = 1'b0;
            m_ops.delete();
            exp_q.delete();
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
        end else begin
            check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            check("out_valid_model", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0)
                check("out_data_model", 32'(out_data), 32'(exp_q[0]));
            if (out_valid && out_ready && exp_q.size() != 0)
                void'(exp_q.pop_front());
            if (in_valid && in_ready)
                model_beat(in_data, op, acc_en, in_last);
        end
    end

    // Advance to the drive point just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it transfers (bounded).
    task automatic send(input logic [N*W-1:0] d, input logic [2:0] o,
                        input logic ae, input logic last);
        bit ok = 1'b0;
        int n  = 0;
        in_data  = d;
        op       = o;
        acc_en   = ae;
        in_last  = last;
        in_valid = 1'b1;
        while (!ok && n < 200) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ok = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        check("send_accepted", 32'(ok), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        op        = 3'b000;
        acc_en    = 1'b0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(in_ready), 32'd1);
        step();

        // Per-beat OR.
        out_ready = 1'b1;
        send(pk(8'h01, 8'h02, 8'h04, 8'h08), OP_OR, 1'b0, 1'b0);
        @(negedge clk);
        check("perbeat_or_valid", 32'(out_valid), 32'd1);
        check("perbeat_or_data", 32'(out_data), 32'h0F);
        step();

        // NAND accumulation over two beats.
        send(pk(8'hFF, 8'hF0, 8'hFF, 8'hFF), OP_NAND, 1'b1, 1'b0);
        @(negedge clk);
        check("nand_nonlast_no_out", 32'(out_valid), 32'd0);
        step();
        send(pk(8'h3C, 8'hFF, 8'hFF, 8'hFF), OP_NAND, 1'b1, 1'b1);
        @(negedge clk);
        check("nand_acc_valid", 32'(out_valid), 32'd1);
        check("nand_acc_data", 32'(out_data), 32'hCF);
        step();
        @(negedge clk);
        check("nand_single_output", 32'(out_valid), 32'd0);
        step();

        // Backpressure then accept with a simultaneous new beat.
        out_ready = 1'b0;
        send(pk(8'hFF, 8'h0F, 8'hF3, 8'h3F), OP_AND, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_data_held", 32'(out_data), 32'h03);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        send(pk(8'h01, 8'h02, 8'h04, 8'h80), OP_XOR, 1'b0, 1'b0);
        @(negedge clk);
        check("no_bubble_valid", 32'(out_valid), 32'd1);
        check("no_bubble_data", 32'(out_data), 32'h87);
        step();

        // Op and acc_en changes after the first beat are ignored.
        send(pk(8'h11, 8'h22, 8'h44, 8'h88), OP_XOR, 1'b1, 1'b0);
        send(pk(8'h01, 8'h02, 8'h04, 8'h08), OP_AND, 1'b0, 1'b1);
        @(negedge clk);
        check("op_latched_data", 32'(out_data), 32'hF0);
        step();

        // NOT accumulation forwards the last beat's operand 0 inverted.
        send(pk(8'h11, 8'h22, 8'h33, 8'h44), OP_NOT, 1'b1, 1'b0);
        send(pk(8'h5A, 8'h00, 8'h00, 8'h00), OP_AND, 1'b0, 1'b1);
        @(negedge clk);
        check("not_acc_data", 32'(out_data), 32'hA5);
        step();

        // Reset mid-packet discards the partial OR.
        send(pk(8'hF0, 8'h00, 8'h00, 8'h00), OP_OR, 1'b1, 1'b0);
        send(pk(8'h00, 8'h80, 8'h00, 8'h00), OP_OR, 1'b1, 1'b0);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("midpkt_rst_valid", 32'(out_valid), 32'd0);
        step();
        rst_n = 1'b1;
        send(pk(8'h00, 8'h00, 8'h00, 8'h01), OP_OR, 1'b1, 1'b1);
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'h01);
        step();

        // Randomized traffic with random downstream backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(32'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 3) == 0) step();
            if (i == 150) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
